// File: rtl/wb_uart_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_uart_master                                                  |
// | Purpose  : UART-byte-command driven Wishbone (pipelined) single-word       |
// |            master. Frames: opcode, 4 addr bytes MSB first, [4 data bytes]. |
// |            Returns 'K' for writes, 4 data bytes for reads, 'E' on timeout. |
// | Option   : WB_UART_MASTER_AUTOINC_EN adds 'w'/'r' opcodes that reuse the  |
// |            stored address, which is advanced by 4 after every transaction.|
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module wb_uart_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter logic [7:0]  OP_READ        = 8'h52,
  parameter logic [7:0]  RESP_OK        = 8'h4B,
  parameter logic [7:0]  RESP_ERR       = 8'h45
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`ifdef WB_UART_MASTER_AUTOINC_EN
  localparam logic [7:0] OP_WRITE_INC = 8'h77;
  localparam logic [7:0] OP_READ_INC  = 8'h72;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_DATA     = 3'd2,
    S_BUS_REQ  = 3'd3,
    S_BUS_WAIT = 3'd4,
    S_TX_LOAD  = 3'd5,
    S_TX_GAP   = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] tx_shift;
  logic [1:0]  byte_cnt;
  logic [1:0]  tx_left;
  logic [15:0] tmo_cnt;
  logic        err;
  logic        cyc;
  logic        stb;
  logic        tx_fire;
  logic        bus_ack;
  logic        bus_abort;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // State register; async reset drops every state-derived output at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and state-derived bus/TX strobes
  always_comb begin
    state_nxt = state;
    cyc       = 1'b0;
    stb       = 1'b0;
    tx_fire   = 1'b0;
    bus_ack   = 1'b0;
    bus_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == OP_WRITE || i_rx_data == OP_READ) state_nxt = S_ADDR;
`ifdef WB_UART_MASTER_AUTOINC_EN
          else if (i_rx_data == OP_WRITE_INC) state_nxt = S_DATA;
          else if (i_rx_data == OP_READ_INC)  state_nxt = S_BUS_REQ;
`endif
        end
      end
      S_ADDR: begin
        if (i_rx_valid && byte_cnt == 2'd3) state_nxt = we ? S_DATA : S_BUS_REQ;
      end
      S_DATA: begin
        if (i_rx_valid && byte_cnt == 2'd3) state_nxt = S_BUS_REQ;
      end
      S_BUS_REQ: begin
        cyc = 1'b1;
        stb = 1'b1;
        // An ACK only counts once the request is accepted (no stall)
        if (!i_wb_stall && i_wb_ack) begin
          bus_ack   = 1'b1;
          state_nxt = S_TX_LOAD;
        end else if (tmo_hit) begin
          bus_abort = 1'b1;
          state_nxt = S_TX_LOAD;
        end else if (!i_wb_stall) begin
          state_nxt = S_BUS_WAIT;
        end
      end
      S_BUS_WAIT: begin
        cyc = 1'b1;
        if (i_wb_ack) begin
          bus_ack   = 1'b1;
          state_nxt = S_TX_LOAD;
        end else if (tmo_hit) begin
          bus_abort = 1'b1;
          state_nxt = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        if (!i_tx_busy) begin
          tx_fire   = 1'b1;
          state_nxt = S_TX_GAP;
        end
      end
      S_TX_GAP: begin
        state_nxt = (tx_left != 2'd0) ? S_TX_LOAD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame capture, timeout counting, response staging and address advance
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we       <= 1'b0;
      addr     <= 32'h0;
      wdata    <= 32'h0;
      tx_shift <= 32'h0;
      byte_cnt <= 2'd0;
      tx_left  <= 2'd0;
      tmo_cnt  <= 16'h0;
      err      <= 1'b0;
    end else begin
      err <= bus_abort;
      case (state)
        S_IDLE: begin
          byte_cnt <= 2'd0;
          if (i_rx_valid) begin
            if (i_rx_data == OP_WRITE)     we <= 1'b1;
            else if (i_rx_data == OP_READ) we <= 1'b0;
`ifdef WB_UART_MASTER_AUTOINC_EN
            else if (i_rx_data == OP_WRITE_INC) we <= 1'b1;
            else if (i_rx_data == OP_READ_INC)  we <= 1'b0;
`endif
          end
        end
        S_ADDR: begin
          if (i_rx_valid) begin
            addr     <= {addr[23:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (i_rx_valid) begin
            wdata    <= {wdata[23:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_BUS_REQ, S_BUS_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (bus_ack || bus_abort) begin
            tmo_cnt <= 16'h0;
            if (bus_abort) begin
              tx_shift <= {RESP_ERR, 24'h0};
              tx_left  <= 2'd0;
            end else if (we) begin
              tx_shift <= {RESP_OK, 24'h0};
              tx_left  <= 2'd0;
            end else begin
              tx_shift <= i_wb_data;
              tx_left  <= 2'd3;
            end
`ifdef WB_UART_MASTER_AUTOINC_EN
            addr <= {addr[31:2] + 30'd1, 2'b00};
`endif
          end
        end
        S_TX_LOAD: begin
          if (tx_fire) tx_shift <= {tx_shift[23:0], 8'h00};
        end
        S_TX_GAP: begin
          if (tx_left != 2'd0) tx_left <= tx_left - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_wb_cyc   = cyc;
  assign o_wb_stb   = stb;
  assign o_wb_we    = cyc & we;
  assign o_wb_addr  = {addr[31:2], 2'b00};
  assign o_wb_data  = wdata;
  assign o_wb_sel   = cyc ? 4'hF : 4'h0;
  assign o_tx_valid = tx_fire;
  assign o_tx_data  = tx_fire ? tx_shift[31:24] : 8'h00;
  assign o_busy     = (state != S_IDLE);
  assign o_err      = err;

endmodule
`default_nettype wire
